// File: rtl/gray_seq_sched.sv
// Purpose : round-robin scheduler sharing one 3-bit Gray up/down counter between two requesters.
// Latency : grant/busy one edge after the request; N counter steps on the next N edges; done for one cycle; then IDLE.
// Backpressure: none; requests are level signals sampled only in IDLE, and a losing requester simply waits.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low; clears all state
//   req0/req1       request levels, sampled only in IDLE
//   dir0/dir1       run direction (0 = up, 1 = down), captured with the grant
//   steps0/steps1   run length in counter steps, captured with the grant
//   grant           one-hot owner (bit0 = requester 0), 00 when idle
//   busy            high whenever the FSM is not in IDLE
//   done            one-cycle completion pulse (DONE state)
//   gray            current Gray counter value
//   Spres / Sfut    present (registered) / next (combinational) FSM state
module gray_seq_sched #(
  parameter int STEPS_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               dir0,
  input  logic               dir1,
  input  logic [STEPS_W-1:0] steps0,
  input  logic [STEPS_W-1:0] steps1,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               done,
  output logic [2:0]         gray,
  output logic [1:0]         Spres,
  output logic [1:0]         Sfut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_gray;
  logic [1:0]         r_grant;
  logic               r_last;   // index of the requester served most recently
  logic               r_dir;
  logic [STEPS_W-1:0] r_rem;

  logic               w_any;
  logic               w_pick1;
  logic               w_dir;
  logic [STEPS_W-1:0] w_steps;

  // One Gray position forward or backward: convert to binary, step, convert back.
  // The 3-bit arithmetic wraps, which gives the seamless 100 <-> 000 transition.
  function automatic logic [2:0] gray_step(input logic [2:0] g, input logic down);
    logic [2:0] b;
    logic [2:0] nb;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    nb   = down ? (b - 3'd1) : (b + 3'd1);
    return nb ^ (nb >> 1);
  endfunction

  // Requester 1 wins if it is alone, or on a tie when requester 0 was served last.
  assign w_any   = req0 | req1;
  assign w_pick1 = req1 & (~req0 | ~r_last);
  assign w_dir   = w_pick1 ? dir1 : dir0;
  assign w_steps = w_pick1 ? steps1 : steps0;

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = (w_steps != '0) ? S_RUN : S_DONE;
        end
      end
      // r_rem of 0 cannot occur in RUN; treating it like the final step keeps the FSM from sticking.
      S_RUN:   w_next = (r_rem <= STEP_ONE) ? S_DONE : S_RUN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gray  <= 3'b000;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_dir   <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick1 ? 2'b10 : 2'b01;
            r_last  <= w_pick1;
            r_dir   <= w_dir;
            r_rem   <= w_steps;
          end
        end
        S_RUN: begin
          r_gray <= gray_step(r_gray, r_dir);
          r_rem  <= r_rem - STEP_ONE;
        end
        S_DONE:  r_grant <= 2'b00;
        default: r_grant <= 2'b00;
      endcase
    end
  end

  assign grant = r_grant;
  assign gray  = r_gray;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign Spres = r_state;
  assign Sfut  = w_next;

endmodule
